// File: rtl/key_search_pkg.sv
// ============================================================================
//  key_search_pkg : shared state encoding and printable-range defaults
//  Rev 1.0
// ============================================================================
`default_nettype none

package key_search_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_EVAL      = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   localparam logic [7:0]  c_PT_LO    = 8'h20;
   localparam logic [7:0]  c_PT_HI    = 8'h7E;
   localparam logic [23:0] c_STRIDE_1 = 24'd1;

endpackage

`default_nettype wire

// File: rtl/key_search_pt_printable.sv
// ============================================================================
//  pt_printable : flags a snooped plaintext write whose byte is unprintable
//  Rev 1.0
// ============================================================================
`default_nettype none

module pt_printable
   import key_search_pkg::*;
#(
   parameter logic [7:0] PT_LO = c_PT_LO,
   parameter logic [7:0] PT_HI = c_PT_HI
) (
   input  logic [7:0] i_addr,
   input  logic [7:0] i_data,
   input  logic       i_wren,
   output logic       o_bad
);

   logic w_out_of_range;

   // Address 0 carries the message length, not text, so it is never judged.
   assign w_out_of_range = (i_data < PT_LO) || (i_data > PT_HI);
   assign o_bad          = i_wren && (i_addr != 8'd0) && w_out_of_range;

endmodule

`default_nettype wire

// File: rtl/key_search.sv
// ============================================================================
//  key_search : steps an arc4 engine through candidate keys until the
//               snooped plaintext is fully printable or the key space wraps
//  Rev 1.0
// ============================================================================
`default_nettype none

module key_search
   import key_search_pkg::*;
#(
   parameter logic [7:0] PT_LO = c_PT_LO,
   parameter logic [7:0] PT_HI = c_PT_HI
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key_start,
   input  logic [23:0] key_stride,
   output logic [23:0] key,
   output logic        key_valid,
   output logic        arc4_en,
   output logic [23:0] arc4_key,
   input  logic        arc4_rdy,
   input  logic [7:0]  pt_addr,
   input  logic [7:0]  pt_wrdata,
   input  logic        pt_wren
);

   state_t      r_state;
   logic        r_rdy;
   logic [23:0] r_cur_key;
   logic [23:0] r_stride;
   logic [23:0] r_key;
   logic        r_key_valid;
   logic        r_arc4_en;
   logic [23:0] r_arc4_key;
   logic        r_bad;

   logic        w_bad_wr;
   logic [24:0] w_sum;

   pt_printable #(
      .PT_LO (PT_LO),
      .PT_HI (PT_HI)
   ) u_pt_printable (
      .i_addr (pt_addr),
      .i_data (pt_wrdata),
      .i_wren (pt_wren),
      .o_bad  (w_bad_wr)
   );

   // Bit 24 is the carry that marks the end of the key space.
   assign w_sum = {1'b0, r_cur_key} + {1'b0, r_stride};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rdy       <= 1'b1;
         r_cur_key   <= 24'd0;
         r_stride    <= c_STRIDE_1;
         r_key       <= 24'd0;
         r_key_valid <= 1'b0;
         r_arc4_en   <= 1'b0;
         r_arc4_key  <= 24'd0;
         r_bad       <= 1'b0;
      end else begin
         r_arc4_en <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (en) begin
                  r_cur_key   <= key_start;
                  r_stride    <= (key_stride == 24'd0) ? c_STRIDE_1 : key_stride;
                  r_key_valid <= 1'b0;
                  r_rdy       <= 1'b0;
                  r_state     <= ST_START;
               end
            end
            ST_START: begin
               if (arc4_rdy) begin
                  r_arc4_en  <= 1'b1;
                  r_arc4_key <= r_cur_key;
                  r_bad      <= 1'b0;
                  r_state    <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (w_bad_wr) begin
                  r_bad <= 1'b1;
               end
               if (!arc4_rdy) begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               // A write coinciding with arc4_rdy rising still counts.
               if (w_bad_wr) begin
                  r_bad <= 1'b1;
               end
               if (arc4_rdy) begin
                  r_state <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (!r_bad) begin
                  r_key       <= r_cur_key;
                  r_key_valid <= 1'b1;
                  r_rdy       <= 1'b1;
                  r_state     <= ST_DONE;
               end else if (w_sum[24]) begin
                  r_rdy   <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cur_key <= w_sum[23:0];
                  r_state   <= ST_START;
               end
            end
            default: begin
               r_rdy   <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rdy       = r_rdy;
   assign key       = r_key;
   assign key_valid = r_key_valid;
   assign arc4_en   = r_arc4_en;
   assign arc4_key  = r_arc4_key;

endmodule

`default_nettype wire
